// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types for the MEM-stage access controller.
// Holds the controller state enum and memory-op bit positions.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_ctrl_state_t;

  localparam int MEM_OP_READ  = 1;
  localparam int MEM_OP_WRITE = 0;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: data-cache request/response channel.
// master = pipeline controller, slave = data cache.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 64
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata
  );

endinterface

// File: rtl/mem_req_timer.sv
// mem_req_timer: counts cycles spent waiting for a cache response.
// o_expire fires on the LIMIT-th enabled cycle since the last clear.
module mem_req_timer #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  // wait-cycle counter, cleared whenever the FSM leaves WAIT
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-cache sequencer with stall/flush.
// Optional MEM_ACCESS_TIMEOUT_EN bounds WAIT with a sticky error.
module mem_access_ctrl
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [DATA_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  branch_decision_in,
  input  logic [DATA_WIDTH-1:0] target_in,
  mem_access_ctrl_if.master     dc,
  output logic                  stall_out,
  output logic                  flush_out,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  load_valid_out,
  output logic [DATA_WIDTH-1:0] load_data_out,
  output logic                  err_out
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  mem_ctrl_state_t       r_state;
  mem_ctrl_state_t       w_next;
  logic [1:0]            w_op;
  logic                  w_op_present;
  logic                  w_op_we;
  logic                  w_timeout;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_load_data;

  assign w_op         = {mem_read_in, mem_write_in};
  assign w_op_present = |w_op;
  assign w_op_we      = w_op[MEM_OP_WRITE];

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic w_expire;
  logic r_err;

  mem_req_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state != ST_WAIT),
    .i_en     (r_state == ST_WAIT),
    .o_expire (w_expire)
  );

  // a response in the final cycle still wins over the timeout
  assign w_timeout = w_expire && !dc.resp_valid;

  // sticky error flag, only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err_out = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_out   = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_op_present) w_next = ST_REQ;
      ST_REQ:  if (dc.req_ready) w_next = ST_WAIT;
      ST_WAIT: begin
        if (dc.resp_valid || w_timeout) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // capture the op on issue and the read data on response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
    end else begin
      if (r_state == ST_IDLE && w_op_present) begin
        r_we    <= w_op_we;
        r_addr  <= addr_in;
        r_wdata <= wdata_in;
      end
      if (r_state == ST_WAIT) begin
        if (dc.resp_valid) begin
          if (!r_we) r_load_data <= dc.resp_rdata;
        end else if (w_timeout) begin
          r_load_data <= '0;
        end
      end
    end
  end

  // outputs decoded from state, captured regs and EX/MEM inputs
  always_comb begin
    dc.req_valid   = (r_state == ST_REQ);
    dc.req_we      = r_we;
    dc.req_addr    = r_addr;
    dc.req_wdata   = r_wdata;
    stall_out      = (r_state == ST_IDLE && w_op_present)
                   || (r_state == ST_REQ)
                   || (r_state == ST_WAIT);
    flush_out      = branch_decision_in && !stall_out;
    redirect_pc    = flush_out ? target_in : '0;
    load_valid_out = (r_state == ST_DONE) && !r_we;
    load_data_out  = r_load_data;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl.
// Timeout scenario is built only with MEM_ACCESS_TIMEOUT_EN.
module tb_mem_access_ctrl;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_read_in;
  logic          mem_write_in;
  logic [DW-1:0] addr_in;
  logic [DW-1:0] wdata_in;
  logic          branch_decision_in;
  logic [DW-1:0] target_in;
  logic          stall_out;
  logic          flush_out;
  logic [DW-1:0] redirect_pc;
  logic          load_valid_out;
  logic [DW-1:0] load_data_out;
  logic          err_out;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_ctrl_if #(.DATA_WIDTH(DW)) dc ();

  mem_access_ctrl #(
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .addr_in            (addr_in),
    .wdata_in           (wdata_in),
    .branch_decision_in (branch_decision_in),
    .target_in          (target_in),
    .dc                 (dc.master),
    .stall_out          (stall_out),
    .flush_out          (flush_out),
    .redirect_pc        (redirect_pc),
    .load_valid_out     (load_valid_out),
    .load_data_out      (load_data_out),
    .err_out            (err_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_in        = 1'b0;
    mem_write_in       = 1'b0;
    branch_decision_in = 1'b0;
    target_in          = '0;
    dc.req_ready       = 1'b0;
    dc.resp_valid      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    addr_in       = '0;
    wdata_in      = '0;
    dc.resp_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (dc.req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_req_valid: got %b want 0", dc.req_valid);
    end
    n_cmp++;
    if (stall_out !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stall: got %b want 0", stall_out);
    end
    n_cmp++;
    if (flush_out !== 1'b0) begin
      n_err++;
      $display("FAIL rst_flush: got %b want 0", flush_out);
    end
    n_cmp++;
    if (load_valid_out !== 1'b0 || load_data_out !== '0) begin
      n_err++;
      $display("FAIL rst_load: got %b/%h want 0/0",
               load_valid_out, load_data_out);
    end
    n_cmp++;
    if (err_out !== 1'b0) begin
      n_err++;
      $display("FAIL rst_err: got %b want 0", err_out);
    end
  endtask

  task automatic test_load();
    int stalls;
    stalls = 0;
    mem_read_in  = 1'b1;
    addr_in      = 64'h1000;
    dc.req_ready = 1'b1;
    #1;
    if (stall_out === 1'b1) stalls++;
    tick();
    n_cmp++;
    if (dc.req_valid !== 1'b1 || dc.req_addr !== 64'h1000
        || dc.req_we !== 1'b0) begin
      n_err++;
      $display("FAIL load_req: got v=%b a=%h we=%b want 1/1000/0",
               dc.req_valid, dc.req_addr, dc.req_we);
    end
    if (stall_out === 1'b1) stalls++;
    tick();
    dc.req_ready  = 1'b0;
    dc.resp_valid = 1'b1;
    dc.resp_rdata = 64'hDEAD_BEEF;
    #1;
    if (stall_out === 1'b1) stalls++;
    tick();
    dc.resp_valid = 1'b0;
    mem_read_in   = 1'b0;
    #1;
    if (stall_out === 1'b1) stalls++;
    n_cmp++;
    if (stalls !== 3) begin
      n_err++;
      $display("FAIL load_stall_cycles: got %0d want 3", stalls);
    end
    n_cmp++;
    if (load_valid_out !== 1'b1 || load_data_out !== 64'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL load_done: got %b/%h want 1/deadbeef",
               load_valid_out, load_data_out);
    end
    tick();
    n_cmp++;
    if (load_valid_out !== 1'b0 || load_data_out !== 64'hDEAD_BEEF
        || stall_out !== 1'b0) begin
      n_err++;
      $display("FAIL load_hold: got v=%b d=%h s=%b want 0/deadbeef/0",
               load_valid_out, load_data_out, stall_out);
    end
  endtask

  task automatic test_store_backpressure();
    int bad;
    bad = 0;
    mem_write_in = 1'b1;
    addr_in      = 64'h2000;
    wdata_in     = 64'h55;
    dc.req_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      addr_in       = 64'hBAD0 + 64'(i);
      wdata_in      = 64'hEE;
      dc.resp_valid = 1'b1;
      #1;
      if (dc.req_valid !== 1'b1 || dc.req_addr !== 64'h2000
          || dc.req_wdata !== 64'h55 || dc.req_we !== 1'b1
          || load_valid_out !== 1'b0 || stall_out !== 1'b1) bad++;
      if (i < 3) tick();
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL store_hold: got %0d bad cycles want 0", bad);
    end
    dc.req_ready  = 1'b1;
    dc.resp_valid = 1'b0;
    tick();
    dc.req_ready = 1'b0;
    n_cmp++;
    if (dc.req_valid !== 1'b0 || stall_out !== 1'b1) begin
      n_err++;
      $display("FAIL store_wait: got v=%b s=%b want 0/1",
               dc.req_valid, stall_out);
    end
    dc.resp_valid = 1'b1;
    tick();
    dc.resp_valid = 1'b0;
    mem_write_in  = 1'b0;
    #1;
    n_cmp++;
    if (load_valid_out !== 1'b0 || stall_out !== 1'b0
        || load_data_out !== 64'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL store_done: got v=%b s=%b d=%h want 0/0/deadbeef",
               load_valid_out, stall_out, load_data_out);
    end
    tick();
  endtask

  task automatic test_read_write_both();
    mem_read_in  = 1'b1;
    mem_write_in = 1'b1;
    addr_in      = 64'h3000;
    wdata_in     = 64'h77;
    dc.req_ready = 1'b1;
    tick();
    n_cmp++;
    if (dc.req_we !== 1'b1 || dc.req_wdata !== 64'h77) begin
      n_err++;
      $display("FAIL both_we: got we=%b d=%h want 1/77",
               dc.req_we, dc.req_wdata);
    end
    tick();
    dc.req_ready  = 1'b0;
    dc.resp_valid = 1'b1;
    dc.resp_rdata = 64'h1234;
    tick();
    dc.resp_valid = 1'b0;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    #1;
    n_cmp++;
    if (load_valid_out !== 1'b0 || load_data_out !== 64'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL both_done: got %b/%h want 0/deadbeef",
               load_valid_out, load_data_out);
    end
    tick();
  endtask

  task automatic test_branch();
    branch_decision_in = 1'b1;
    target_in          = 64'h400;
    #1;
    n_cmp++;
    if (flush_out !== 1'b1 || redirect_pc !== 64'h400
        || stall_out !== 1'b0) begin
      n_err++;
      $display("FAIL br_flush: got f=%b pc=%h s=%b want 1/400/0",
               flush_out, redirect_pc, stall_out);
    end
    branch_decision_in = 1'b0;
    #1;
    n_cmp++;
    if (flush_out !== 1'b0 || redirect_pc !== '0) begin
      n_err++;
      $display("FAIL br_none: got f=%b pc=%h want 0/0",
               flush_out, redirect_pc);
    end
    target_in = '0;
  endtask

  task automatic test_branch_with_mem();
    mem_read_in        = 1'b1;
    addr_in            = 64'h6000;
    branch_decision_in = 1'b1;
    target_in          = 64'h800;
    dc.req_ready       = 1'b1;
    #1;
    n_cmp++;
    if (flush_out !== 1'b0 || redirect_pc !== '0) begin
      n_err++;
      $display("FAIL brm_idle: got f=%b pc=%h want 0/0",
               flush_out, redirect_pc);
    end
    tick();
    tick();
    dc.req_ready  = 1'b0;
    dc.resp_valid = 1'b1;
    dc.resp_rdata = 64'hCAFE;
    n_cmp++;
    if (flush_out !== 1'b0 || stall_out !== 1'b1) begin
      n_err++;
      $display("FAIL brm_wait: got f=%b s=%b want 0/1",
               flush_out, stall_out);
    end
    tick();
    dc.resp_valid = 1'b0;
    mem_read_in   = 1'b0;
    #1;
    n_cmp++;
    if (flush_out !== 1'b1 || redirect_pc !== 64'h800
        || load_valid_out !== 1'b1 || load_data_out !== 64'hCAFE) begin
      n_err++;
      $display("FAIL brm_done: got f=%b pc=%h v=%b d=%h want 1/800/1/cafe",
               flush_out, redirect_pc, load_valid_out, load_data_out);
    end
    branch_decision_in = 1'b0;
    target_in          = '0;
    tick();
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    bad = 0;
    mem_read_in  = 1'b1;
    addr_in      = 64'h7000;
    dc.req_ready = 1'b1;
    tick();
    tick();
    dc.req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (stall_out !== 1'b1 || err_out !== 1'b0) bad++;
      tick();
    end
    mem_read_in = 1'b0;
    #1;
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL to_wait: got %0d bad cycles want 0", bad);
    end
    n_cmp++;
    if (err_out !== 1'b1 || load_data_out !== '0
        || stall_out !== 1'b0) begin
      n_err++;
      $display("FAIL to_done: got e=%b d=%h s=%b want 1/0/0",
               err_out, load_data_out, stall_out);
    end
    tick();
    tick();
    n_cmp++;
    if (err_out !== 1'b1) begin
      n_err++;
      $display("FAIL to_sticky: got %b want 1", err_out);
    end
  endtask
`endif

  task automatic test_reset_in_wait();
    mem_read_in  = 1'b1;
    addr_in      = 64'h5000;
    dc.req_ready = 1'b1;
    tick();
    tick();
    dc.req_ready = 1'b0;
    n_cmp++;
    if (stall_out !== 1'b1 || dc.req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rw_inwait: got s=%b v=%b want 1/0",
               stall_out, dc.req_valid);
    end
    reset       = 1'b1;
    mem_read_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    dc.resp_valid = 1'b1;
    dc.resp_rdata = 64'hFFFF;
    #1;
    n_cmp++;
    if (stall_out !== 1'b0 || dc.req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rw_late: got s=%b v=%b want 0/0",
               stall_out, dc.req_valid);
    end
    tick();
    dc.resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (load_valid_out !== 1'b0 || load_data_out !== '0
        || stall_out !== 1'b0 || err_out !== 1'b0
        || dc.req_addr !== '0) begin
      n_err++;
      $display("FAIL rw_after: got v=%b d=%h s=%b e=%b a=%h want zeros",
               load_valid_out, load_data_out, stall_out, err_out,
               dc.req_addr);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_backpressure();
    test_read_write_both();
    test_branch();
    test_branch_with_mem();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of address/data paths.
REQ-002 Parameter TIMEOUT_CYCLES, default 256, WAIT-state cycle limit (used only with MEM_ACCESS_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_read_in, mem_write_in  in  1 each  EX/MEM memory control bits (read=bit1, write=bit0).
REQ-006 addr_in  in  DATA_WIDTH  EX/MEM ALU result used as memory address.
REQ-007 wdata_in  in  DATA_WIDTH  EX/MEM store data.
REQ-008 branch_decision_in  in  1 and target_in  in  DATA_WIDTH  EX/MEM branch outcome and target.
REQ-009 req_valid  out  1, req_ready  in  1, req_we  out  1, req_addr  out  DATA_WIDTH, req_wdata  out  DATA_WIDTH  data-cache request channel.
REQ-010 resp_valid  in  1, resp_rdata  in  DATA_WIDTH  data-cache response channel.
REQ-011 stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM registers.
REQ-012 flush_out  out  1, redirect_pc  out  DATA_WIDTH  squash younger stages, new fetch PC.
REQ-013 load_valid_out  out  1, load_data_out  out  DATA_WIDTH  load result to MEM/WB.
REQ-014 err_out  out  1  sticky timeout error (0 when macro absent).

Function
REQ-015 FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-016 IDLE: if mem_read_in|mem_write_in, capture addr_in, wdata_in, req_we=mem_write_in into internal regs, go REQ; else stay IDLE.
REQ-017 REQ: req_valid=1 with captured addr/wdata/we held stable; on req_ready go WAIT; else stay.
REQ-018 WAIT: on resp_valid capture resp_rdata (reads only), go DONE; stores also wait for resp_valid.
REQ-019 DONE: one cycle; load_valid_out=1 iff captured op was read; go IDLE unconditionally.
REQ-020 stall_out=1 when (IDLE and op present) or REQ or WAIT; 0 in DONE and idle-with-no-op; combinational.
REQ-021 Minimum stall for a memory op = 3 cycles (req_ready and resp_valid each asserted on first eligible cycle).
REQ-022 resp_valid outside WAIT ignored; req_ready outside REQ ignored.
REQ-023 flush_out=branch_decision_in & ~stall_out, combinational; redirect_pc=target_in whenever flush_out=1, else 0.
REQ-024 Simultaneous mem op and taken branch (store/load with branch impossible, but if both): memory sequence takes precedence; flush_out asserts in DONE cycle.
REQ-025 load_data_out holds last captured read data until next read completes.
REQ-026 mem_read_in and mem_write_in both 1: treat as write.

Reset
REQ-027 Reset in any state: next cycle state=IDLE, req_valid=0, stall_out=0, flush_out=0, load_valid_out=0, load_data_out=0, err_out=0, captured regs=0; in-flight request abandoned, its late response ignored.

Configuration
REQ-028 Macro MEM_ACCESS_TIMEOUT_EN: when defined, counter runs in WAIT; after TIMEOUT_CYCLES cycles without resp_valid, set err_out (sticky until reset), load_data_out=0, go DONE; when undefined, no counter, WAIT unbounded, err_out tied 0.

Structure
REQ-029 Shared package pipeline_pkg holds state enum mem_ctrl_state_t and constant MEM_OP_READ/MEM_OP_WRITE bit positions.
REQ-030 One sub-module mem_req_timer (counter, clear, expire) instantiated only under MEM_ACCESS_TIMEOUT_EN.

Verification
REQ-031 Load addr 0x1000, req_ready=1, resp_valid next cycle with 0xDEAD_BEEF -> stall 3 cycles, DONE load_valid_out=1, load_data_out=0xDEADBEEF.
REQ-032 Store addr 0x2000 data 0x55, req_ready low 4 cycles -> req_valid/addr/wdata stable all 4 cycles, req_we=1, load_valid_out never 1.
REQ-033 branch_decision_in=1, target 0x400, no mem op -> flush_out=1, redirect_pc=0x400 same cycle, stall_out=0.
REQ-034 Reset asserted in WAIT, resp_valid arrives 2 cycles later -> state IDLE, no load_valid_out, outputs zero.
REQ-035 With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> after 8 WAIT cycles err_out=1 sticky, load_data_out=0, stall released.
